rs_enc_ctrl: RTL and testbench
==============================

Name: rs_enc_ctrl

Overview:
Front-end controller and feedback stage of the RS(255,239) systematic encoder over GF(2^8).
- Accepts message symbols and forms the feedback symbol mr = din ^ r_last, which drives every generator tap stage (g0..g15).
- Passes message symbols straight through, then shifts the 16 parity symbols out of the last tap register.
- Frames the resulting 255-symbol codeword on the output.

Parameters:
N, 255, codeword length in symbols
K, 239, message length in symbols
PAR, 16, parity symbols (N-K); must equal the number of tap stages

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-low reset
din  input  8  message symbol
din_valid  input  1  din qualifier
din_sop  input  1  first message symbol of a block
din_ready  output  1  controller can accept a symbol this cycle
r_last  input  8  output of final tap register (r_15)
mr  output  8  feedback symbol to all tap stages (combinational)
dout  output  8  codeword symbol
dout_valid  output  1  dout qualifier
dout_sop  output  1  first codeword symbol
dout_eop  output  1  last codeword symbol
err  output  1  one-cycle pulse: message stream broken

Behaviour:
- Reset (rst=0 at clk edge): state IDLE, counter 0; dout=0, dout_valid=0, dout_sop=0, dout_eop=0, err=0, din_ready=0.
- mr is combinational:
  - mr = din ^ r_last in MSG when din_valid=1.
  - mr = 0 in every other case.
- Tap registers are free-running with no enable. While the controller is outside MSG, it holds mr=0 so the chain only shifts.
- FSM states: IDLE, MSG, PAR, FLUSH. Counter cnt is 8 bits.
- IDLE:
  - din_ready=1.
  - din_valid & din_sop: accept the symbol, cnt<=1, go to MSG.
  - din_valid without din_sop: symbol is dropped with no error.
- MSG:
  - din_ready=1. Each accepted symbol increments cnt.
  - din_sop inside MSG is ignored; the symbol is treated as data.
  - Accepting symbol number K: cnt<=0, go to PAR.
  - din_valid=0 in MSG: abort. err pulses 1 on the next cycle, cnt<=0, go to FLUSH; no further dout_valid for this block.
- PAR:
  - din_ready=0, mr=0.
  - dout<=r_last each cycle, for PAR cycles. Parity is emitted highest-degree first, i.e. the last tap register's contents.
  - After PAR cycles, go to IDLE.
- FLUSH: din_ready=0, mr=0, dout_valid=0 for PAR cycles, then IDLE. This clears the tap chain.
- Output timing (all outputs registered, latency 1 cycle from acceptance):
  - Each accepted message symbol appears on dout with dout_valid=1.
  - dout_sop marks the first message symbol.
  - The PAR parity symbols follow contiguously, and dout_eop marks the last parity symbol.
  - A valid codeword is exactly N contiguous dout_valid cycles.
- Back-to-back blocks: din_ready rises in the cycle after the last parity cycle. A new sop is accepted there with no gap.
- Reset mid-block: immediate return to IDLE and all outputs cleared. The tap chain is cleared by its own reset.
- err is a single-cycle pulse. It never asserts in IDLE or PAR.

Optional Feature:
RS_SHORTEN_EN
- Defined:
  - Adds input k_len (8 bits), sampled with din_sop.
  - MSG ends after k_len symbols instead of K, giving a shortened codeword of k_len+PAR symbols.
  - k_len=0 or k_len>K is clamped to K.
- Undefined: no k_len port, and the message length is fixed at K.

Test Plan:
- Reset: hold rst=0 for 3 cycles with din_valid=1 -> dout_valid=0, err=0, mr=0, din_ready=0; din_ready=1 the cycle after rst=1.
- All-zero message: 239 contiguous din=0x00 starting with sop, tap model attached -> 255 dout_valid cycles, all 0x00; dout_sop on cycle 1 and dout_eop on cycle 255 after first output; din_ready low for exactly 16 cycles.
- Feedback check: r_last forced to 0x5A by the bench, din=0x01 in MSG -> mr=0x5B; in PAR with din=0xFF -> mr=0x00 and dout tracks r_last one cycle later.
- Reference codeword: message 0x01..0xEF with real tap chain -> 16 parity symbols match the software RS(255,239) model (prim poly 0x11D), and message symbols are passed unchanged.
- Gap abort: drop din_valid at message symbol 100 -> err pulse one cycle later, no dout_eop, 16 FLUSH cycles, then a clean next block encodes correctly.
- RS_SHORTEN_EN: k_len=10 -> 26 output symbols, eop on the 26th, parity matching the zero-padded full-length code.

Source files
------------

// File: rtl/rs_enc_ctrl_if.sv
// Handshake and data bundle between the RS(255,239) encoder controller, its message
// source and the external generator tap chain. RS_SHORTEN_EN adds the k_len field.
interface rs_enc_ctrl_if;
  logic [7:0] din;
  logic       din_valid;
  logic       din_sop;
  logic       din_ready;
  logic [7:0] r_last;
  logic [7:0] mr;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_sop;
  logic       dout_eop;
  logic       err;
`ifdef RS_SHORTEN_EN
  logic [7:0] k_len;

  modport master (
    output din, din_valid, din_sop, r_last, k_len,
    input  din_ready, mr, dout, dout_valid, dout_sop, dout_eop, err
  );
  modport slave (
    input  din, din_valid, din_sop, r_last, k_len,
    output din_ready, mr, dout, dout_valid, dout_sop, dout_eop, err
  );
`else
  modport master (
    output din, din_valid, din_sop, r_last,
    input  din_ready, mr, dout, dout_valid, dout_sop, dout_eop, err
  );
  modport slave (
    input  din, din_valid, din_sop, r_last,
    output din_ready, mr, dout, dout_valid, dout_sop, dout_eop, err
  );
`endif
endinterface

// File: rtl/rs_enc_ctrl.sv
// RS(255,239) encoder front-end: feedback symbol, message pass-through, parity drain
// and codeword framing. Define RS_SHORTEN_EN for a per-block message length (k_len).
module rs_enc_ctrl #(
  parameter int unsigned N   = 255,
  parameter int unsigned K   = 239,
  parameter int unsigned PAR = 16
) (
  input  logic         clk,
  input  logic         rst,
  rs_enc_ctrl_if.slave bus
);

  localparam logic [7:0] K_LEN      = 8'(K);
  localparam logic [7:0] LAST_PAR   = 8'(PAR - 1);
  localparam logic [7:0] LAST_FLUSH = 8'(N - K - 1);

  typedef enum logic [1:0] {S_IDLE, S_MSG, S_PAR, S_FLUSH} state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] dout_q, dout_d;
  logic       dv_q, dv_d;
  logic       sop_q, sop_d;
  logic       eop_q, eop_d;
  logic       err_q, err_d;
  logic       rdy_q, rdy_d;
  logic [7:0] mr_c;
  logic [7:0] len_q;
  logic [7:0] sop_len;
  logic       sop_acc;

  assign sop_acc = (state_q == S_IDLE) && rdy_q && bus.din_valid && bus.din_sop;

`ifdef RS_SHORTEN_EN
  always_comb begin
    sop_len = bus.k_len;
    if ((bus.k_len == '0) || (bus.k_len > K_LEN)) sop_len = K_LEN;
  end

  always_ff @(posedge clk) begin
    if (!rst)         len_q <= K_LEN;
    else if (sop_acc) len_q <= sop_len;
  end
`else
  assign sop_len = K_LEN;
  assign len_q   = K_LEN;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = '0;
    dv_d    = 1'b0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    err_d   = 1'b0;
    mr_c    = '0;
    case (state_q)
      S_IDLE: begin
        // The sop symbol is the first message symbol, so it feeds the chain too.
        if (sop_acc) begin
          mr_c   = bus.din ^ bus.r_last;
          dout_d = bus.din;
          dv_d   = 1'b1;
          sop_d  = 1'b1;
          if (sop_len == 8'd1) begin
            state_d = S_PAR;
            cnt_d   = '0;
          end else begin
            state_d = S_MSG;
            cnt_d   = 8'd1;
          end
        end
      end
      S_MSG: begin
        if (bus.din_valid) begin
          mr_c   = bus.din ^ bus.r_last;
          dout_d = bus.din;
          dv_d   = 1'b1;
          if (cnt_q == len_q - 8'd1) begin
            state_d = S_PAR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          err_d   = 1'b1;
          state_d = S_FLUSH;
          cnt_d   = '0;
        end
      end
      S_PAR: begin
        dout_d = bus.r_last;
        dv_d   = 1'b1;
        if (cnt_q == LAST_PAR) begin
          eop_d   = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_FLUSH: begin
        // mr stays zero so every tap stage shifts out to zero.
        if (cnt_q == LAST_FLUSH) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    rdy_d = (state_d == S_IDLE) || (state_d == S_MSG);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end

  assign bus.mr         = mr_c;
  assign bus.din_ready  = rdy_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dv_q;
  assign bus.dout_sop   = sop_q;
  assign bus.dout_eop   = eop_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_rs_enc_ctrl.sv
// Scoreboard bench for rs_enc_ctrl with a GF(2^8) tap-chain model (poly 0x11D) and
// a long-division reference for the parity symbols.
module tb_rs_enc_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rs_enc_ctrl_if bus();

  rs_enc_ctrl #(.N(255), .K(239), .PAR(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
  } exp_t;

  exp_t       exp_q[$];
  int         n_vec    = 0;
  int         n_err    = 0;
  int         err_seen = 0;
  logic [7:0] g   [0:16];
  logic [7:0] tap [0:15];
  logic [7:0] msg [0:238];
  logic [7:0] par [0:15];
  logic       force_en  = 1'b0;
  logic [7:0] force_val = 8'h00;
  logic       prev_valid = 1'b0;

  assign bus.r_last = force_en ? force_val : tap[15];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction

  function automatic exp_t mk(input logic [7:0] d, input logic sop, input logic eop);
    exp_t e;
    e.d   = d;
    e.sop = sop;
    e.eop = eop;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // g(x) = prod_{i=0..15} (x + alpha^i)
  task automatic init_gen();
    logic [7:0] a;
    for (int k = 0; k < 17; k++) g[k] = 8'h00;
    g[0] = 8'h01;
    a    = 8'h01;
    for (int i = 0; i < 16; i++) begin
      for (int j = 16; j > 0; j--) g[j] = g[j-1] ^ gmul(g[j], a);
      g[0] = gmul(g[0], a);
      a    = gmul(a, 8'h02);
    end
  endtask

  task automatic calc_parity(input int len);
    logic [7:0] d [0:254];
    logic [7:0] c;
    for (int i = 0; i < len + 16; i++) d[i] = (i < len) ? msg[i] : 8'h00;
    for (int i = 0; i < len; i++) begin
      c = d[i];
      for (int j = 1; j <= 16; j++) d[i+j] = d[i+j] ^ gmul(c, g[16-j]);
    end
    for (int j = 0; j < 16; j++) par[j] = d[len+j];
  endtask

  // Generator tap chain driven by the controller's feedback symbol.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) tap[i] <= 8'h00;
    end else begin
      tap[0] <= gmul(g[0], bus.mr);
      for (int i = 1; i < 16; i++) tap[i] <= tap[i-1] ^ gmul(g[i], bus.mr);
    end
  end

  // Monitor: pop and compare whenever the DUT presents a codeword symbol.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.err === 1'b1) err_seen++;
      if (bus.dout_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected dout_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("dout", 32'(bus.dout), 32'(e.d));
          chk("dout_sop", 32'(bus.dout_sop), 32'(e.sop));
          chk("dout_eop", 32'(bus.dout_eop), 32'(e.eop));
        end
        if (bus.dout_sop !== 1'b1) chk("contiguous codeword", 32'(prev_valid), 32'd1);
      end
      prev_valid = bus.dout_valid;
    end
  end

  task automatic wait_ready();
    int b;
    b = 0;
    while (bus.din_ready !== 1'b1 && b < 64) begin
      @(negedge clk);
      b++;
    end
    if (b == 64) chk("din_ready timeout", 32'(bus.din_ready), 32'd1);
  endtask

  // One block from msg[0:len-1]; gap >= 0 drops din_valid at that symbol index.
  task automatic run_block(input int len, input int gap);
    int n_msg;
    calc_parity(len);
    n_msg = (gap >= 0) ? gap : len;
    for (int i = 0; i < n_msg; i++) exp_q.push_back(mk(msg[i], i == 0, 1'b0));
    if (gap < 0)
      for (int j = 0; j < 16; j++) exp_q.push_back(mk(par[j], 1'b0, j == 15));
    wait_ready();
    for (int i = 0; i < len; i++) begin
      if (i == gap) begin
        bus.din_valid = 1'b0;
        bus.din_sop   = 1'b0;
        @(negedge clk);
        chk("err pulse on abort", 32'(bus.err), 32'd1);
        chk("no dout after abort", 32'(bus.dout_valid), 32'd0);
        break;
      end
      bus.din       = msg[i];
      bus.din_valid = 1'b1;
      bus.din_sop   = (i == 0);
      @(negedge clk);
    end
    bus.din_valid = 1'b0;
    bus.din_sop   = 1'b0;
    bus.din       = 8'h00;
    for (int c = 0; c < 16; c++) begin
      chk("din_ready low in drain", 32'(bus.din_ready), 32'd0);
      if (gap >= 0 && c == 1) chk("err single pulse", 32'(bus.err), 32'd0);
      @(negedge clk);
    end
    chk("din_ready after drain", 32'(bus.din_ready), 32'd1);
  endtask

  task automatic load_ref();
    for (int i = 0; i < 239; i++) msg[i] = 8'(i + 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    init_gen();
    bus.din       = 8'h33;
    bus.din_valid = 1'b1;
    bus.din_sop   = 1'b1;
`ifdef RS_SHORTEN_EN
    bus.k_len     = 8'd0;
`endif

    // Reset held with traffic present.
    repeat (3) begin
      @(negedge clk);
      chk("reset dout_valid", 32'(bus.dout_valid), 32'd0);
      chk("reset err", 32'(bus.err), 32'd0);
      chk("reset mr", 32'(bus.mr), 32'd0);
      chk("reset din_ready", 32'(bus.din_ready), 32'd0);
      chk("reset dout", 32'(bus.dout), 32'd0);
    end
    rst           = 1'b1;
    bus.din_valid = 1'b0;
    bus.din_sop   = 1'b0;
    @(negedge clk);
    chk("din_ready after reset", 32'(bus.din_ready), 32'd1);

    // All-zero message, then the reference message back-to-back.
    for (int i = 0; i < 239; i++) msg[i] = 8'h00;
    run_block(239, -1);
    load_ref();
    run_block(239, -1);

    // Abort at message symbol 100, then a clean block.
    run_block(239, 99);
    run_block(239, -1);

    // Feedback path with r_last forced by the bench.
    force_en  = 1'b1;
    force_val = 8'h5A;
    wait_ready();
    for (int i = 0; i < 239; i++) begin
      bus.din       = 8'h01;
      bus.din_valid = 1'b1;
      bus.din_sop   = (i == 0);
      exp_q.push_back(mk(8'h01, i == 0, 1'b0));
      #1;
      if (i < 4) chk("mr feedback", 32'(bus.mr), 32'h5B);
      @(negedge clk);
    end
    for (int c = 0; c < 16; c++) begin
      force_val     = 8'(8'hA0 + c);
      bus.din       = 8'hFF;
      bus.din_valid = 1'b1;
      bus.din_sop   = 1'b0;
      exp_q.push_back(mk(8'(8'hA0 + c), 1'b0, c == 15));
      #1;
      chk("mr zero in parity", 32'(bus.mr), 32'd0);
      chk("din_ready low in parity", 32'(bus.din_ready), 32'd0);
      @(negedge clk);
    end
    bus.din_valid = 1'b0;
    force_en      = 1'b0;
    chk("din_ready after forced block", 32'(bus.din_ready), 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset in the middle of a block, then a clean block.
    load_ref();
    wait_ready();
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(mk(msg[i], i == 0, 1'b0));
      bus.din       = msg[i];
      bus.din_valid = 1'b1;
      bus.din_sop   = (i == 0);
      @(negedge clk);
    end
    rst           = 1'b0;
    bus.din_valid = 1'b0;
    bus.din_sop   = 1'b0;
    @(negedge clk);
    chk("mid reset dout_valid", 32'(bus.dout_valid), 32'd0);
    chk("mid reset din_ready", 32'(bus.din_ready), 32'd0);
    chk("mid reset dout", 32'(bus.dout), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("din_ready after mid reset", 32'(bus.din_ready), 32'd1);
    run_block(239, -1);

`ifdef RS_SHORTEN_EN
    // Shortened block, then an out-of-range length clamped to K.
    bus.k_len = 8'd10;
    run_block(10, -1);
    bus.k_len = 8'd250;
    run_block(239, -1);
    bus.k_len = 8'd0;
`endif

    begin
      int b;
      b = 0;
      while (exp_q.size() != 0 && b < 20) begin
        @(negedge clk);
        b++;
      end
    end
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    chk("err pulse count", 32'(err_seen), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
